alu_exec_unit: RTL and testbench

Registered 64-bit Y86-64 execute-stage ALU that consumes OPq operand transactions and returns results with condition codes. Sits between decode and memory stages; accepts operands over a valid/ready handshake and returns results over a second valid/ready handshake with a two-entry output buffer. It is the sequential responder wrapped around the combinational add/sub/and/xor cores.

---
 rtl/y86_alu_pkg.sv | 20 ++
 rtl/alu64_core.sv | 47 ++++
 rtl/alu_exec_unit.sv | 134 +++++++++++++
 tb/tb_alu_exec_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// rtl/y86_alu_pkg.sv - shared types and constants for the Y86-64 execute-stage ALU
package y86_alu_pkg;

    localparam int         W_DEFAULT = 64;
    localparam logic [2:0] CC_RESET  = 3'b100;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        XOR = 4'd3
    } alu_op_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/alu64_core.sv
// rtl/alu64_core.sv - combinational add/sub/and/xor core with {ZF,SF,OF} and invalid-op flag
// Condition codes are only generated when ALU_EXEC_CC_EN is defined; otherwise cc is 000.
module alu64_core
    import y86_alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [3:0]   ifun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic [2:0]   cc,
    output logic         err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (alu_op_t'(ifun))
            ADD:     result = b + a;
            SUB:     result = b - a;
            AND:     result = b & a;
            XOR:     result = b ^ a;
            default: err    = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_CC_EN
    cc_t flags;

    always_comb begin
        flags.zf = (result == '0) && !err;
        flags.sf = result[W-1];
        flags.of = 1'b0;
        case (alu_op_t'(ifun))
            ADD:     flags.of = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            SUB:     flags.of = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
            default: flags.of = 1'b0;
        endcase
    end

    assign cc = flags;
`else
    assign cc = 3'b000;
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute-stage ALU with valid/ready in/out and a two-entry output buffer
// Optional condition-code generation and cc_q register: ALU_EXEC_CC_EN.
module alu_exec_unit
    import y86_alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [2:0]   out_cc,
    output logic         out_err,
    output logic [2:0]   cc_q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t   state, next_state;
    logic [W-1:0] core_result;
    logic [2:0]   core_cc;
    logic         core_err;
    logic [W-1:0] skid_result;
    logic [2:0]   skid_cc;
    logic         skid_err;
    logic         accept, deliver;
    logic         load_main, load_skid, skid_to_main;

    alu64_core #(.W(W)) u_core (
        .ifun   (in_ifun),
        .a      (in_a),
        .b      (in_b),
        .result (core_result),
        .cc     (core_cc),
        .err    (core_err)
    );

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        next_state   = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (accept && !deliver) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (accept && deliver) begin
                    load_main  = 1'b1;
                end else if (deliver) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    next_state   = BUSY;
                    skid_to_main = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_cc      <= 3'b000;
            out_err     <= 1'b0;
            skid_result <= '0;
            skid_cc     <= 3'b000;
            skid_err    <= 1'b0;
        end else begin
            if (load_main) begin
                out_result <= core_result;
                out_cc     <= core_cc;
                out_err    <= core_err;
            end else if (skid_to_main) begin
                out_result <= skid_result;
                out_cc     <= skid_cc;
                out_err    <= skid_err;
            end
            if (load_skid) begin
                skid_result <= core_result;
                skid_cc     <= core_cc;
                skid_err    <= core_err;
            end
        end
    end

`ifdef ALU_EXEC_CC_EN
    // Architectural flags follow acceptance order, independent of output backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_RESET;
        end else if (accept && !core_err) begin
            cc_q <= core_cc;
        end
    end
`else
    assign cc_q = 3'b000;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

`ifdef ALU_EXEC_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ifun;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [2:0]  out_cc;
    logic        out_err;
    logic [2:0]  cc_q;

    int n_compared;
    int n_mismatched;

    alu_exec_unit #(.W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ifun    (in_ifun),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cc     (out_cc),
        .out_err    (out_err),
        .cc_q       (cc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ccx(input logic [2:0] v);
        return CC_EN ? {61'd0, v} : 64'd0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        in_valid = v;
        in_ifun  = f;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 64'd0, 64'd0);
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_result", out_result, 64'd0);
        check("rst_out_cc", {61'd0, out_cc}, 64'd0);
        check("rst_out_err", {63'd0, out_err}, 64'd0);
        check("rst_cc_q", {61'd0, cc_q}, ccx(3'b100));
        #2 rst_n = 1'b1;
        @(negedge clk);

        // XOR, one cycle latency
        drive(1'b1, 4'd3, 64'hD552AA, 64'h52AEBA);
        step();
        check("xor_valid", {63'd0, out_valid}, 64'd1);
        check("xor_result", out_result, 64'h87FC10);
        check("xor_cc", {61'd0, out_cc}, ccx(3'b000));
        check("xor_cc_q", {61'd0, cc_q}, ccx(3'b000));

        // ADD signed overflow
        drive(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        step();
        check("add_of_result", out_result, 64'h8000_0000_0000_0000);
        check("add_of_cc", {61'd0, out_cc}, ccx(3'b011));
        check("add_of_err", {63'd0, out_err}, 64'd0);

        // SUB to zero, then 0 - 1
        drive(1'b1, 4'd1, 64'd5, 64'd5);
        step();
        check("sub_zero_result", out_result, 64'd0);
        check("sub_zero_cc", {61'd0, out_cc}, ccx(3'b100));
        drive(1'b1, 4'd1, 64'd1, 64'd0);
        step();
        check("sub_neg_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_neg_cc", {61'd0, out_cc}, ccx(3'b010));
        check("sub_neg_cc_q", {61'd0, cc_q}, ccx(3'b010));

        // Invalid ifun after zero-result SUB keeps cc_q
        drive(1'b1, 4'd1, 64'd5, 64'd5);
        step();
        drive(1'b1, 4'd7, 64'd3, 64'd9);
        step();
        check("inv_err", {63'd0, out_err}, 64'd1);
        check("inv_result", out_result, 64'd0);
        check("inv_cc", {61'd0, out_cc}, 64'd0);
        check("inv_cc_q", {61'd0, cc_q}, ccx(3'b100));
        drive(1'b0, 4'd0, 64'd0, 64'd0);
        step();
        check("drain_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure: three back-to-back items with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 64'd1, 64'd2);
        step();
        check("bp1_in_ready", {63'd0, in_ready}, 64'd1);
        check("bp1_result", out_result, 64'd3);
        drive(1'b1, 4'd2, 64'hF0, 64'h0F);
        step();
        check("bp2_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp2_result", out_result, 64'd3);
        check("bp2_cc_q", {61'd0, cc_q}, ccx(3'b100));
        drive(1'b1, 4'd3, 64'hFF, 64'h0F);
        step();
        check("bp3_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp3_stable", out_result, 64'd3);
        check("bp3_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        step();
        check("bp4_result", out_result, 64'd0);
        check("bp4_cc", {61'd0, out_cc}, ccx(3'b100));
        check("bp4_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        check("bp5_result", out_result, 64'hF0);
        check("bp5_valid", {63'd0, out_valid}, 64'd1);
        check("bp5_cc_q", {61'd0, cc_q}, ccx(3'b000));
        drive(1'b0, 4'd0, 64'd0, 64'd0);
        step();
        check("bp6_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 64'd2, 64'd2);
        step();
        drive(1'b1, 4'd0, 64'd4, 64'd4);
        step();
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b0, 4'd0, 64'd0, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_cc_q", {61'd0, cc_q}, ccx(3'b100));
        check("arst_result", out_result, 64'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'd3, 64'd1, 64'd2);
        step();
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_result", out_result, 64'd3);
        drive(1'b0, 4'd0, 64'd0, 64'd0);
        step();
        check("post_rst_drain", {63'd0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
